div_seq: RTL and testbench
==========================

# div_seq

Multi-cycle sequencer for the execute-stage divider used by DIV/DIVU. It accepts a divide request from EX, runs a 32-step radix-2 restoring divide, and returns {remainder, quotient} for the HI/LO write path. It drives the `stall_div` signal that the hazard unit consumes as `stall_divE` to freeze F/D/E while a divide is in flight. It cancels cleanly on an exception flush.

## Interface
Parameters:
- `WIDTH`, 32, operand width; the step count equals `WIDTH`.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  divide request from EX; held high by the stalled pipeline until the result is consumed.
- `signed_div`  in  1  1 = DIV (signed), 0 = DIVU.
- `opdata1`  in  WIDTH  dividend (rs).
- `opdata2`  in  WIDTH  divisor (rt).
- `annul`  in  1  exception flush (`flush_except`); aborts any divide in progress.
- `result`  out  2*WIDTH  {remainder → HI, quotient → LO}.
- `ready`  out  1  `result` is valid.
- `stall_div`  out  1  combinational: `start & ~ready & ~annul`; feeds the hazard unit's `stall_divE`.

## Operation
- States: IDLE, DIVZERO, ON, END.
- IDLE, when `start & ~annul`:
  - Latch the absolute values of both operands (only when `signed_div`), the sign of each, and `signed_div`.
  - Next state is DIVZERO if `opdata2 == 0`, otherwise ON.
  - Clear the step counter.
- ON: one restoring step per cycle on a (WIDTH+1)-bit partial remainder.
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor.
  - If the result is non-negative, keep the difference and set quotient bit 0.
  - After step `WIDTH` (counter == WIDTH-1), go to END.
- Sign fix-up on entering END:
  - Negate the quotient if `signed_div` and the operand signs differ.
  - Negate the remainder if `signed_div` and the dividend was negative.
- DIVZERO: next state END with `result = 0`. No trap; the ISA leaves the result undefined.
- END: `ready = 1` and `result` is held stable.
  - Stay in END while `start = 1`.
  - On `start = 0`, go to IDLE and drop `ready`.
- `annul` in any state: next state IDLE, `ready = 0`, and `result` is not updated. `annul` has priority over `start` in the same cycle.
- Arithmetic wraps at WIDTH bits: `0x80000000 / -1` signed gives q = `0x80000000`, r = 0, with no overflow flag.

## Timing
- Reset values: state = IDLE, `ready = 0`, `result = 0`, counter = 0. `stall_div` follows its combinational equation (0 when `start = 0`).
- Normal latency: with `start` first high in cycle t (in IDLE), ON covers t+1..t+WIDTH and `ready` is high from cycle t+WIDTH+1.
- `stall_div` is high for cycles t..t+WIDTH and low once `ready = 1`, which releases the pipeline that same cycle.
- Divide-by-zero latency: `ready` is high at t+2.
- Back-to-back divides: a new request is accepted only from IDLE, so `start` must drop for at least one cycle between them. The pipeline guarantees this by advancing the instruction.
- Operand changes on `opdata1`/`opdata2` after cycle t are ignored.
- `rst` mid-divide behaves like `annul`, and additionally clears `result`.

## Structure
- Shared package `div_pkg`:
  - State encoding (IDLE = 2'b00, DIVZERO = 2'b01, ON = 2'b10, END = 2'b11).
  - `DIV_WIDTH` = 32.
  - Counter width = $clog2(DIV_WIDTH).
- Sub-module `div_step`: combinational single iteration.
  - Inputs: partial remainder, quotient, divisor.
  - Outputs: next remainder, next quotient.
  - Instantiated once and registered by the FSM.

## Test plan
- DIVU `0x00000064 / 0x00000007`, start held → `ready` at t+33, `result = {0x00000002, 0x0000000E}`, `stall_div` high exactly 33 cycles.
- DIV `0xFFFFFFF9 (-7) / 0x00000002` → `result = {0xFFFFFFFF, 0xFFFFFFFD}`; DIV `0x80000000 / 0xFFFFFFFF` → `{0x00000000, 0x80000000}`.
- Divisor 0 (signed and unsigned) → `ready` at t+2, `result = 0`, `stall_div` high for 2 cycles.
- `annul` pulsed at step 10 → IDLE next cycle, `ready` never asserts, prior `result` unchanged; a fresh `start` two cycles later completes correctly.
- `start` and `annul` high together in IDLE → remains in IDLE, `stall_div = 0`.
- `rst` asserted at step 20 → all outputs at reset values next cycle; a following DIVU `0xFFFFFFFF / 0x00000010` → `{0x0000000F, 0x0FFFFFFF}`.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and sizing for the sequential divider
package div_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int CNT_W = $clog2(DIV_WIDTH);
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    DIVZERO = 2'b01,
    ON      = 2'b10,
    END     = 2'b11
  } div_state_e;
endpackage

// File: rtl/div_step.sv
// div_step: one radix-2 restoring divide iteration
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);
  logic [WIDTH+1:0] sh;
  logic [WIDTH:0] diff;
  logic ge;
  // shift in the next dividend bit, trial-subtract, restore on borrow
  always_comb begin
    sh = {rem_i, quo_i[WIDTH-1]};
    ge = sh >= {2'b00, dvs_i};
    diff = sh[WIDTH:0] - {1'b0, dvs_i};
    rem_o = ge ? diff : sh[WIDTH:0];
    quo_o = {quo_i[WIDTH-2:0], ge};
  end
endmodule

// File: rtl/div_seq.sv
// div_seq: multi-cycle DIV/DIVU sequencer with pipeline stall and flush abort
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_div,
  input  logic [WIDTH-1:0]     opdata1,
  input  logic [WIDTH-1:0]     opdata2,
  input  logic                 annul,
  output logic [2*WIDTH-1:0]   result,
  output logic                 ready,
  output logic                 stall_div
);
  localparam int CW = $clog2(WIDTH);
  div_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH:0] rem_q, rem_d, rem_n;
  logic [WIDTH-1:0] quo_q, quo_d, quo_n, dvs_q, dvs_d;
  logic sgn_q, sgn_d, s1_q, s1_d, s2_q, s2_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic ready_q, ready_d;
  logic [WIDTH-1:0] abs1, abs2, quo_fix, rem_fix;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i(rem_q),
    .quo_i(quo_q),
    .dvs_i(dvs_q),
    .rem_o(rem_n),
    .quo_o(quo_n)
  );

  // operand magnitudes on accept and sign restoration of the final step
  always_comb begin
    abs1 = (signed_div & opdata1[WIDTH-1]) ? -opdata1 : opdata1;
    abs2 = (signed_div & opdata2[WIDTH-1]) ? -opdata2 : opdata2;
    quo_fix = (sgn_q & (s1_q ^ s2_q)) ? -quo_n : quo_n;
    rem_fix = (sgn_q & s1_q) ? -rem_n[WIDTH-1:0] : rem_n[WIDTH-1:0];
  end

  // next-state: accept, iterate, finish, hold until the pipeline consumes; flush wins
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    sgn_d = sgn_q;
    s1_d = s1_q;
    s2_d = s2_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = ~|opdata2 ? DIVZERO : ON;
        cnt_d = '0;
        rem_d = '0;
        quo_d = abs1;
        dvs_d = abs2;
        sgn_d = signed_div;
        s1_d = opdata1[WIDTH-1];
        s2_d = opdata2[WIDTH-1];
      end
      DIVZERO: begin
        state_d = END;
        result_d = '0;
      end
      ON: begin
        rem_d = rem_n;
        quo_d = quo_n;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = END;
          result_d = {rem_fix, quo_fix};
        end
      end
      END: state_d = start ? END : IDLE;
      default: state_d = IDLE;
    endcase
    if (annul) begin
      state_d = IDLE;
      result_d = result_q;
    end
    ready_d = state_d == END;
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      sgn_q <= 1'b0;
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      result_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      sgn_q <= sgn_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      result_q <= result_d;
      ready_q <= ready_d;
    end
  end

  assign result = result_q;
  assign ready = ready_q;
  assign stall_div = start & ~ready_q & ~annul;
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: scoreboard bench for div_seq against an arithmetic reference
module tb_div_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic signed_div = 1'b0;
  logic annul = 1'b0;
  logic [31:0] opdata1 = '0;
  logic [31:0] opdata2 = '0;
  logic [63:0] result;
  logic ready;
  logic stall_div;
  int n_chk = 0;
  int n_fail = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_exp = '0;
  logic ready_prev = 1'b0;

  div_seq #(.WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .signed_div(signed_div),
    .opdata1(opdata1),
    .opdata2(opdata2),
    .annul(annul),
    .result(result),
    .ready(ready),
    .stall_div(stall_div)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 0) return 64'd0;
    sa = s ? longint'($signed(a)) : longint'({32'd0, a});
    sb = s ? longint'($signed(b)) : longint'({32'd0, b});
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ready && !ready_prev) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_ready: got result %h with empty scoreboard", result);
      end else chk("result", result, exp_q.pop_front());
    end
    ready_prev = ready;
  end

  task automatic run_div(input bit s, input logic [31:0] a, input logic [31:0] b);
    int lat, stalls, exp_lat;
    lat = -1;
    stalls = 0;
    exp_lat = (b == 0) ? 2 : 33;
    @(posedge clk); #1;
    start = 1'b1;
    signed_div = s;
    opdata1 = a;
    opdata2 = b;
    last_exp = model(s, a, b);
    exp_q.push_back(last_exp);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (ready) begin
        lat = n;
        break;
      end
      stalls += int'(stall_div);
      @(posedge clk); #1;
      opdata1 = $urandom;
      opdata2 = $urandom;
      signed_div = 1'($urandom);
    end
    chk("latency", lat, exp_lat);
    chk("stall_cycles", stalls, exp_lat);
    chk("stall_at_ready", stall_div, 0);
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      chk("ready_held", ready, 1);
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ready_drop", ready, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int seen;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", ready, 0);
    chk("reset_result", result, 0);
    chk("reset_stall", stall_div, 0);

    run_div(1'b0, 32'h00000064, 32'h00000007);
    chk("model_100_7", last_exp, 64'h00000002_0000000E);
    run_div(1'b1, 32'hFFFFFFF9, 32'h00000002);
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF);
    run_div(1'b1, 32'h12345678, 32'h00000000);
    run_div(1'b0, 32'hDEADBEEF, 32'h00000000);
    run_div(1'b0, 32'h00000064, 32'h00000007);

    // flush at step 10: no ready, result untouched
    @(posedge clk); #1;
    start = 1'b1;
    signed_div = 1'b0;
    opdata1 = 32'h0BADF00D;
    opdata2 = 32'h00000013;
    repeat (10) @(posedge clk);
    #1 annul = 1'b1;
    @(negedge clk);
    chk("annul_stall", stall_div, 0);
    @(posedge clk); #1;
    annul = 1'b0;
    start = 1'b0;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ready) seen++;
      if (n == 0) chk("annul_result_kept", result, last_exp);
    end
    chk("annul_no_ready", seen, 0);
    run_div(1'b1, 32'hFFFF0000, 32'h00000300);

    // start and annul together in IDLE must not launch a divide
    @(posedge clk); #1;
    start = 1'b1;
    annul = 1'b1;
    opdata2 = 32'h00000005;
    @(negedge clk);
    chk("start_annul_stall", stall_div, 0);
    @(posedge clk); #1;
    start = 1'b0;
    annul = 1'b0;
    run_div(1'b0, 32'h0000ABCD, 32'h00000005);

    // reset mid-divide at step 20
    @(posedge clk); #1;
    start = 1'b1;
    opdata1 = 32'h77777777;
    opdata2 = 32'h00000003;
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_result", result, 0);
    chk("rst_stall", stall_div, 0);
    run_div(1'b0, 32'hFFFFFFFF, 32'h00000010);

    for (int i = 0; i < 30; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = 32'hFFFFFFFF;
        3: b = 32'h80000000;
        default: b = $urandom;
      endcase
      if (i % 7 == 3) a = 32'h80000000;
      run_div(1'($urandom), a, b);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drain", 64'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
